// File: rtl/sqrt_seq_pkg.sv
// Shared types and sizing helpers for the sequential integer square root unit.
package sqrt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width: enough to count width/2 steps plus headroom.
    function automatic int cnt_width(input int w);
        return $clog2(w / 2) + 1;
    endfunction

endpackage

// File: rtl/sqrt_seq_step.sv
// One restoring square-root recurrence step: consumes two radicand bits and
// resolves one root bit.
module sqrt_seq_step #(
    parameter int width = 16
) (
    input  logic [width/2+1:0] rem_in,
    input  logic [1:0]         bits,
    input  logic [width/2-1:0] q_in,
    output logic [width/2+1:0] rem_out,
    output logic [width/2-1:0] q_out
);

    localparam int H = width / 2;

    logic [H+3:0] ext;
    logic [H+3:0] sub;
    logic         ge;

    assign ext = {rem_in, bits};
    assign sub = {2'b00, q_in, 2'b01};
    assign ge  = (ext >= sub);

    // A non-negative trial always fits the narrower remainder, so the low bits suffice.
    always_comb begin
        rem_out = ext[H+1:0];
        if (ge) begin
            rem_out = ext[H+1:0] - sub[H+1:0];
        end
        q_out = {q_in[H-2:0], ge};
    end

endmodule

// File: rtl/sqrt_seq.sv
// Sequential floor square root with valid/ready handshakes on both sides.
// Define SQRT_SEQ_REM_EN to expose the final remainder on R (otherwise R is 0).
module sqrt_seq
    import sqrt_seq_pkg::*;
#(
    parameter int width = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [width-1:0]   X,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [width/2-1:0] Q,
    output logic [width/2:0]   R
);

    localparam int H  = width / 2;
    localparam int CW = cnt_width(width);

    state_t          state;
    state_t          next_state;
    logic [width-1:0] rad;
    logic [H-1:0]    q;
    logic [H-1:0]    q_step;
    logic [H+1:0]    rem;
    logic [H+1:0]    rem_step;
    logic [CW-1:0]   cnt;
    logic            last;

    assign last = (cnt == CW'(H - 1));

    sqrt_seq_step #(.width(width)) u_step (
        .rem_in  (rem),
        .bits    (rad[width-1:width-2]),
        .q_in    (q),
        .rem_out (rem_step),
        .q_out   (q_step)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (in_valid_i)  next_state = BUSY;
            BUSY:    if (last)        next_state = DONE;
            DONE:    if (out_ready_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Radicand is consumed MSB-first by shifting it left two bits per step.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rad <= '0;
            q   <= '0;
            rem <= '0;
            cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        rad <= X;
                        q   <= '0;
                        rem <= '0;
                        cnt <= '0;
                    end
                end
                BUSY: begin
                    rad <= {rad[width-3:0], 2'b00};
                    q   <= q_step;
                    rem <= rem_step;
                    cnt <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign Q           = q;

`ifdef SQRT_SEQ_REM_EN
    assign R = rem[H:0];
`else
    assign R = '0;
`endif

endmodule

// File: tb/tb_sqrt_seq.sv
// Self-checking bench for sqrt_seq (width=16) against an arithmetic reference model.
module tb_sqrt_seq;

    localparam int WIDTH      = 16;
    localparam int NUM_RANDOM = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  q;
    logic [8:0]  r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sqrt_seq #(.width(WIDTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .X           (x),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .Q           (q),
        .R           (r)
    );

    function automatic int ref_root(input int v);
        int k = 0;
        while ((k + 1) * (k + 1) <= v) k++;
        return k;
    endfunction

    function automatic int ref_rem(input int v);
        int k = ref_root(v);
`ifdef SQRT_SEQ_REM_EN
        return v - k * k;
`else
        return k - k;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Called just after a falling edge with the DUT idle; returns the result
    // and the number of edges from the handshake cycle to out_valid.
    task automatic applyStimulus(input logic [15:0] val, output int cycles,
                                 output logic [7:0] q_got, output logic [8:0] r_got);
        in_valid = 1'b1;
        x        = val;
        cycles   = 0;
        do begin
            @(negedge clk);
            cycles++;
            in_valid = 1'b0;
        end while (!out_valid && cycles < 100);
        checkOutput("done_reached", 32'(out_valid), 32'd1);
        q_got = q;
        r_got = r;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [15:0] dir_x [6] = '{16'd144, 16'd150, 16'd0, 16'd65535, 16'd500, 16'd1};
    int          dir_q [6] = '{12, 12, 0, 255, 22, 1};
`ifdef SQRT_SEQ_REM_EN
    int          dir_r [6] = '{0, 6, 0, 510, 16, 0};
`else
    int          dir_r [6] = '{0, 0, 0, 0, 0, 0};
`endif

    logic [15:0] pending [$];

    initial begin
        int          cyc;
        int          highs;
        int          sent;
        int          recv;
        int          v;
        logic [7:0]  q_got;
        logic [8:0]  r_got;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_q", 32'(q), 32'd0);
        checkOutput("rst_r", 32'(r), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed values");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(dir_x[i], cyc, q_got, r_got);
            checkOutput($sformatf("dir_latency_%0d", dir_x[i]), 32'(cyc), 32'd9);
            checkOutput($sformatf("dir_q_%0d", dir_x[i]), 32'(q_got), 32'(dir_q[i]));
            checkOutput($sformatf("dir_r_%0d", dir_x[i]), 32'(r_got), 32'(dir_r[i]));
            checkOutput($sformatf("dir_model_q_%0d", dir_x[i]), 32'(q_got), 32'(ref_root(int'(dir_x[i]))));
            checkOutput("dir_back_idle", 32'(in_ready), 32'd1);
        end

        $display("[TB] output stall");
        in_valid = 1'b1;
        x        = 16'd200;
        @(negedge clk);
        in_valid = 1'b0;
        cyc      = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("stall_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            x        = 16'($urandom);
            @(negedge clk);
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_q", 32'(q), 32'd14);
            checkOutput("stall_r", 32'(r), 32'(ref_rem(200)));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("stall_release_valid", 32'(out_valid), 32'd0);
        checkOutput("stall_release_ready", 32'(in_ready), 32'd1);

        $display("[TB] reset mid-operation");
        in_valid = 1'b1;
        x        = 16'd1000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_q", 32'(q), 32'd0);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) highs++;
        end
        checkOutput("midrst_no_result", 32'(highs), 32'd0);
        applyStimulus(16'd1000, cyc, q_got, r_got);
        checkOutput("after_rst_q", 32'(q_got), 32'd31);
        checkOutput("after_rst_r", 32'(r_got), 32'(ref_rem(1000)));

        $display("[TB] random back-to-back");
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < NUM_RANDOM && cyc < NUM_RANDOM * 20) begin
            in_valid = (sent < NUM_RANDOM);
            if ($urandom_range(0, 7) == 0) begin
                x = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
            end else begin
                x = 16'($urandom_range(0, 65535));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                pending.push_back(x);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (pending.size() == 0) begin
                    checkOutput("rnd_order", 32'd0, 32'd1);
                end else begin
                    v = int'(pending.pop_front());
                    checkOutput("rnd_q", 32'(q), 32'(ref_root(v)));
                    checkOutput("rnd_r", 32'(r), 32'(ref_rem(v)));
`ifdef SQRT_SEQ_REM_EN
                    checkOutput("rnd_identity", 32'(int'(q) * int'(q) + int'(r)), 32'(v));
                    checkOutput("rnd_r_bound", 32'(int'(r) <= 2 * int'(q)), 32'd1);
`endif
                end
                recv++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("rnd_count", 32'(recv), 32'(NUM_RANDOM));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
